filo_cmd_driver: RTL and testbench
==================================

Name: filo_cmd_driver

Overview:
Clocked command front-end that sits directly upstream of the 16-deep 32-bit stack and is the only block that drives it. Accepts push/pop/clear commands over a valid/ready handshake and sequences one stack operation per command. Checks full/empty before issuing, keeps a shadow occupancy count, and returns popped data and status over a valid/ready response channel. The stack interface is a pulsed-request interface: `stk_req` qualifies `stk_read_write` and `stk_data_in`.

Parameters:
DATA_W, 32, width of data words
DEPTH, 16, stack capacity in words
LAST_W, 6, width of occupancy fields (must hold 0..DEPTH)
SETTLE, 2, cycles waited after stk_req before sampling stack outputs (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept command
cmd_op  input  2  00 push, 01 pop, 10 clear, 11 status (no stack access)
cmd_data  input  DATA_W  push data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  popped word (pop); pushed word (push); 0 otherwise
rsp_err  output  1  command rejected or occupancy mismatch
rsp_last  output  LAST_W  shadow occupancy after the command
stk_req  output  1  one-cycle operation request to stack
stk_read_write  output  1  0 push, 1 pop (stack convention)
stk_data_in  output  DATA_W  push data to stack
stk_reset  output  1  active-high reset to stack
stk_data_out  input  DATA_W  stack read data
stk_empty  input  1  stack empty flag
stk_full  input  1  stack full flag
stk_last  input  LAST_W  stack occupancy
sync_err  output  1  sticky: shadow count disagreed with stk_last

Behaviour:
- States: INIT, IDLE, ISSUE, SETTLE, RESP.
- While reset is low: state=INIT, cnt=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0, stk_req=0, stk_read_write=0, stk_data_in=0, stk_reset=1, sync_err=0.
- INIT:
  - Lasts exactly one cycle after reset rises, with stk_reset=1.
  - Then IDLE, with stk_reset=0.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid&cmd_ready on a clock edge; op and data are latched.
- Push decision, taken at accept:
  - If cnt==DEPTH or stk_full=1: error, go straight to RESP, no stk_req.
  - Otherwise go to ISSUE.
- Pop decision, taken at accept:
  - If cnt==0 or stk_empty=1: error, go straight to RESP, no stk_req.
  - Otherwise go to ISSUE.
- Status command: go straight to RESP with rsp_err=0.
- Clear command:
  - Go to ISSUE; there stk_reset=1 for one cycle instead of stk_req.
  - cnt<=0.
- ISSUE:
  - stk_req=1 for exactly one cycle.
  - stk_read_write and stk_data_in are held stable from ISSUE through the end of SETTLE.
  - cnt increments on push, decrements on pop.
- SETTLE:
  - Lasts SETTLE cycles.
  - On the last SETTLE cycle, the driver samples stk_data_out into rsp_data (pop only) and compares stk_last with cnt.
  - On mismatch: rsp_err=1 and sync_err<=1. sync_err clears only on reset.
- RESP:
  - rsp_valid=1; rsp_data, rsp_err and rsp_last are held until rsp_valid&rsp_ready.
  - Go to IDLE on the cycle after the handshake.
  - cmd_ready=0 in every state except IDLE.
- Latency, with accept at edge N:
  - Normal op: stk_req high in cycle N+1; rsp_valid rises at edge N+2+SETTLE.
  - Rejected or status command: rsp_valid rises at edge N+1.
- Backpressure: rsp_ready held low keeps RESP indefinitely; no new command is accepted.
- Throughput: at most one command in flight.
- cnt saturates at 0..DEPTH and never wraps. Width is LAST_W; rsp_last=cnt.
- Reset asserted mid-operation: immediate return to reset values. Any pending response is discarded; stk_reset is asserted.

Test Plan:
1. Reset low 3 cycles, release -> stk_reset high through release +1 cycle, then cmd_ready=1, rsp_last=0, rsp_valid=0.
2. Push 0x00000010, then 0x00000020, then 0x00000030, each with rsp_ready=1 -> one stk_req per push with stk_read_write=0; rsp_last 1,2,3; rsp_err=0; rsp_valid 2+SETTLE cycles after each accept.
3. Continuing from scenario 2, pop 3 times with the stack model returning its top -> rsp_data 0x30, 0x20, 0x10; rsp_last 2,1,0. A 4th pop -> rsp_err=1, rsp_last=0, no stk_req, rsp_valid one cycle after accept.
4. Push 16 words 1..16 -> rsp_last=16. 17th push -> rsp_err=1, no stk_req, rsp_last stays 16. Clear -> stk_reset pulses 1 cycle, rsp_last=0.
5. Stack model reports stk_last=5 while cnt=2 after a push -> rsp_err=1, sync_err=1, and sync_err remains 1 after later clean commands.
6. rsp_ready held low 10 cycles during a pop response -> rsp_valid and rsp_data stable, cmd_ready=0. Reset asserted in SETTLE -> all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/filo_cmd_driver.sv
// Command front-end for a 16-deep stack: one stack operation per push/pop/clear/status command.
// Latency: accept at edge N -> rsp_valid at N+2+SETTLE (stack op) or N+1 (rejected/status).
// Backpressure: cmd_ready only in IDLE; response held while rsp_ready is low, one command in flight.
module filo_cmd_driver #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LAST_W = 6,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [LAST_W-1:0] rsp_last,
  output logic              stk_req,
  output logic              stk_read_write,
  output logic [DATA_W-1:0] stk_data_in,
  output logic              stk_reset,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_empty,
  input  logic              stk_full,
  input  logic [LAST_W-1:0] stk_last,
  output logic              sync_err
);

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_POP    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam int              SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE - 1);
  localparam logic [LAST_W-1:0] CNT_MAX = LAST_W'(DEPTH);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_SETTLE, ST_RESP} state_t;

  state_t              state_q;
  logic [1:0]          op_q;
  logic [LAST_W-1:0]   cnt_q, cnt_d;
  logic [SC_W-1:0]     settle_q;
  logic                cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q, stk_data_in_q;
  logic [LAST_W-1:0]   rsp_last_q;
  logic                stk_req_q, stk_read_write_q, stk_reset_q, sync_err_q;

  // Shadow occupancy after the latched op; saturates at 0 and DEPTH.
  always_comb begin
    cnt_d = cnt_q;
    case (op_q)
      OP_PUSH:  if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      OP_POP:   if (cnt_q != '0)      cnt_d = cnt_q - 1'b1;
      OP_CLEAR: cnt_d = '0;
      default:  cnt_d = cnt_q;
    endcase
  end

  // Command sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_INIT;
      op_q             <= 2'b00;
      cnt_q            <= '0;
      settle_q         <= '0;
      cmd_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
      rsp_last_q       <= '0;
      stk_req_q        <= 1'b0;
      stk_read_write_q <= 1'b0;
      stk_data_in_q    <= '0;
      stk_reset_q      <= 1'b1;
      sync_err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          stk_reset_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            op_q        <= cmd_op;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= cnt_q;
            case (cmd_op)
              OP_PUSH: begin
                if (cnt_q == CNT_MAX || stk_full) begin
                  rsp_err_q <= 1'b1;
                  state_q   <= ST_RESP;
                end else begin
                  stk_req_q        <= 1'b1;
                  stk_read_write_q <= 1'b0;
                  stk_data_in_q    <= cmd_data;
                  state_q          <= ST_ISSUE;
                end
              end
              OP_POP: begin
                if (cnt_q == '0 || stk_empty) begin
                  rsp_err_q <= 1'b1;
                  state_q   <= ST_RESP;
                end else begin
                  stk_req_q        <= 1'b1;
                  stk_read_write_q <= 1'b1;
                  stk_data_in_q    <= '0;
                  state_q          <= ST_ISSUE;
                end
              end
              OP_CLEAR: begin
                // Clear resets the stack instead of issuing a request.
                stk_reset_q <= 1'b1;
                cnt_q       <= '0;
                state_q     <= ST_ISSUE;
              end
              default: state_q <= ST_RESP;
            endcase
          end
        end
        ST_ISSUE: begin
          stk_req_q   <= 1'b0;
          stk_reset_q <= 1'b0;
          cnt_q       <= cnt_d;
          settle_q    <= '0;
          state_q     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == SC_LAST) begin
            if (op_q == OP_POP)       rsp_data_q <= stk_data_out;
            else if (op_q == OP_PUSH) rsp_data_q <= stk_data_in_q;
            rsp_last_q <= cnt_q;
            if (stk_last != cnt_q) begin
              rsp_err_q  <= 1'b1;
              sync_err_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_RESP: begin
          // Response fields are already settled; valid rises one cycle after entry.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_last       = rsp_last_q;
  assign stk_req        = stk_req_q;
  assign stk_read_write = stk_read_write_q;
  assign stk_data_in    = stk_data_in_q;
  assign stk_reset      = stk_reset_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_filo_cmd_driver.sv
// Directed bench for filo_cmd_driver with a behavioural 16-deep stack model.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Response backpressure exercised explicitly; all waits are cycle-bounded.
module tb_filo_cmd_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [5:0]  rsp_last;
  logic        stk_req;
  logic        stk_read_write;
  logic [31:0] stk_data_in;
  logic        stk_reset;
  logic [31:0] stk_data_out;
  logic        stk_empty;
  logic        stk_full;
  logic [5:0]  stk_last;
  logic        sync_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  filo_cmd_driver dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .rsp_last       (rsp_last),
    .stk_req        (stk_req),
    .stk_read_write (stk_read_write),
    .stk_data_in    (stk_data_in),
    .stk_reset      (stk_reset),
    .stk_data_out   (stk_data_out),
    .stk_empty      (stk_empty),
    .stk_full       (stk_full),
    .stk_last       (stk_last),
    .sync_err       (sync_err)
  );

  // Behavioural stack: acts on the edge that sees stk_req / stk_reset.
  logic [31:0] mem [16];
  logic [5:0]  sp_q = '0;
  logic [31:0] dout_q = '0;
  logic [3:0]  top_idx;
  logic [3:0]  wr_idx;
  bit          ovr = 1'b0;
  logic [5:0]  ovr_val = '0;

  assign top_idx = 4'(sp_q - 6'd1);
  assign wr_idx  = sp_q[3:0];

  always @(posedge clk) begin
    if (stk_reset) begin
      sp_q <= '0;
    end else if (stk_req) begin
      if (!stk_read_write) begin
        if (sp_q < 6'd16) begin
          mem[wr_idx] <= stk_data_in;
          sp_q <= sp_q + 6'd1;
        end
      end else if (sp_q > 6'd0) begin
        dout_q <= mem[top_idx];
        sp_q <= sp_q - 6'd1;
      end
    end
  end

  assign stk_data_out = dout_q;
  assign stk_empty    = (sp_q == 6'd0);
  assign stk_full     = (sp_q == 6'd16);
  assign stk_last     = ovr ? ovr_val : sp_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end: accept, count requests/latency, check response, optional hold, handshake.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] d,
                         input int exp_lat, input int exp_req, input int exp_srst,
                         input logic exp_rw, input logic [31:0] exp_data,
                         input logic exp_err, input logic [5:0] exp_last, input int hold);
    int wait_c = 0;
    int lat    = 0;
    int reqs   = 0;
    int srsts  = 0;
    while (!cmd_ready && wait_c < 20) begin
      @(posedge clk); #1;
      wait_c++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 30) begin
      if (stk_req) begin
        reqs++;
        chk({tag, "_rw"}, stk_read_write, exp_rw);
      end
      if (stk_reset) srsts++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  lat, exp_lat);
    chk({tag, "_req"},  reqs, exp_req);
    chk({tag, "_srst"}, srsts, exp_srst);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"},  rsp_err, exp_err);
    chk({tag, "_last"}, rsp_last, exp_last);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"},  rsp_valid, 1'b1);
      chk({tag, "_hold_data"}, rsp_data, exp_data);
      chk({tag, "_hold_rdy"},  cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, rsp_valid, 1'b0);
    chk({tag, "_idle_rdy"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    // 1. reset and INIT
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stk_reset", stk_reset, 1'b1);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_stk_req",   stk_req, 1'b0);
    chk("rst_sync_err",  sync_err, 1'b0);
    reset = 1'b1;
    #1;
    chk("init_stk_reset", stk_reset, 1'b1);
    chk("init_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("idle_stk_reset", stk_reset, 1'b0);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_rsp_last",  rsp_last, 6'd0);
    chk("idle_rsp_valid", rsp_valid, 1'b0);

    // 2. three pushes
    run_cmd("push10", 2'b00, 32'h10, 4, 1, 0, 1'b0, 32'h10, 1'b0, 6'd1, 0);
    run_cmd("push20", 2'b00, 32'h20, 4, 1, 0, 1'b0, 32'h20, 1'b0, 6'd2, 0);
    run_cmd("push30", 2'b00, 32'h30, 4, 1, 0, 1'b0, 32'h30, 1'b0, 6'd3, 0);

    // 3. pops return LIFO order, then underflow is rejected
    run_cmd("pop30",  2'b01, 32'h0, 4, 1, 0, 1'b1, 32'h30, 1'b0, 6'd2, 0);
    run_cmd("pop20",  2'b01, 32'h0, 4, 1, 0, 1'b1, 32'h20, 1'b0, 6'd1, 0);
    run_cmd("pop10",  2'b01, 32'h0, 4, 1, 0, 1'b1, 32'h10, 1'b0, 6'd0, 0);
    run_cmd("pop_empty", 2'b01, 32'h0, 1, 0, 0, 1'b0, 32'h0, 1'b1, 6'd0, 0);

    // 4. fill to capacity, overflow rejected, clear, status
    for (int i = 1; i <= 16; i++) begin
      run_cmd($sformatf("fill%0d", i), 2'b00, 32'(i), 4, 1, 0, 1'b0, 32'(i), 1'b0, 6'(i), 0);
    end
    run_cmd("push_full", 2'b00, 32'h99, 1, 0, 0, 1'b0, 32'h0, 1'b1, 6'd16, 0);
    run_cmd("clear",     2'b10, 32'h0, 4, 0, 1, 1'b0, 32'h0, 1'b0, 6'd0, 0);
    run_cmd("status0",   2'b11, 32'h0, 1, 0, 0, 1'b0, 32'h0, 1'b0, 6'd0, 0);

    // 5. occupancy mismatch sets sticky sync_err
    run_cmd("pushA", 2'b00, 32'hA, 4, 1, 0, 1'b0, 32'hA, 1'b0, 6'd1, 0);
    chk("sync_clean", sync_err, 1'b0);
    ovr = 1'b1;
    ovr_val = 6'd5;
    run_cmd("pushB_mis", 2'b00, 32'hB, 4, 1, 0, 1'b0, 32'hB, 1'b1, 6'd2, 0);
    ovr = 1'b0;
    chk("sync_set", sync_err, 1'b1);
    run_cmd("status2", 2'b11, 32'h0, 1, 0, 0, 1'b0, 32'h0, 1'b0, 6'd2, 0);
    run_cmd("popB",    2'b01, 32'h0, 4, 1, 0, 1'b1, 32'hB, 1'b0, 6'd1, 0);
    chk("sync_sticky", sync_err, 1'b1);

    // 6. response backpressure for 10 cycles, then reset during SETTLE
    run_cmd("popA_hold", 2'b01, 32'h0, 4, 1, 0, 1'b1, 32'hA, 1'b0, 6'd0, 10);

    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 32'h55;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_issue_req", stk_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_stk_req",   stk_req, 1'b0);
    chk("mid_stk_reset", stk_reset, 1'b1);
    chk("mid_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rsp_data",  rsp_data, 32'h0);
    chk("mid_rsp_err",   rsp_err, 1'b0);
    chk("mid_rsp_last",  rsp_last, 6'd0);
    chk("mid_rw",        stk_read_write, 1'b0);
    chk("mid_data_in",   stk_data_in, 32'h0);
    chk("mid_sync_err",  sync_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rec_cmd_ready", cmd_ready, 1'b1);
    run_cmd("push77", 2'b00, 32'h77, 4, 1, 0, 1'b0, 32'h77, 1'b0, 6'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
